// File: rtl/traffic_conflict_monitor.sv
// traffic_conflict_monitor: safety stage between the traffic controller and the lamps.
// Registers the controller codes, checks them every cycle for conflicting greens,
// invalid codes, illegal phase steps and short yellows. Any fault forces flashing red
// on both approaches until an operator clear followed by a confirmed all-red interval.
module traffic_conflict_monitor #(
   parameter int FLASH_HALF     = 4,
   parameter int MIN_YELLOW     = 3,
   parameter int RECOVER_CYCLES = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] ns_in,
   input  logic [1:0] ew_in,
   input  logic       fault_clr,
   output logic [2:0] ns_lamp,
   output logic [2:0] ew_lamp,
   output logic       fault,
   output logic [2:0] fault_code
);

   localparam logic [1:0] C_RED = 2'b00;
   localparam logic [1:0] C_GRN = 2'b01;
   localparam logic [1:0] C_YEL = 2'b10;
   localparam logic [1:0] C_BAD = 2'b11;

   localparam logic [2:0] LAMP_RED = 3'b100;

   localparam int FW = $clog2(FLASH_HALF) + 1;
   localparam int RW = $clog2(RECOVER_CYCLES) + 1;
   localparam int YW = $clog2(MIN_YELLOW + 1);

   localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_HALF - 1);
   localparam logic [RW-1:0] REC_LAST   = RW'(RECOVER_CYCLES - 1);
   localparam logic [YW-1:0] YEL_MAX    = YW'(MIN_YELLOW);

   typedef enum logic [1:0] {ST_NORMAL, ST_FAULT, ST_RECOVER} state_t;

   state_t          state, state_n;
   logic [1:0]      ns_s, ew_s, ns_p, ew_p;
   logic [YW-1:0]   ns_yc, ew_yc;
   logic [FW-1:0]   flash_cnt, flash_cnt_n;
   logic [RW-1:0]   rec_cnt, rec_cnt_n;
   logic [2:0]      ns_lamp_n, ew_lamp_n, fault_code_n, det_code;
   logic            fault_n, force_red_p;

   function automatic logic [2:0] decode(input logic [1:0] c);
      case (c)
         C_GRN:   return 3'b001;
         C_YEL:   return 3'b010;
         default: return LAMP_RED;
      endcase
   endfunction

   function automatic logic illegal_step(input logic [1:0] p, input logic [1:0] s);
      return (p == C_RED && s == C_YEL) || (p == C_YEL && s == C_GRN) ||
             (p == C_GRN && s == C_RED);
   endfunction

   // Stage-1 capture of controller codes plus the previous captured value for sequence checks
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ns_s <= C_RED;
         ew_s <= C_RED;
         ns_p <= C_RED;
         ew_p <= C_RED;
      end else begin
         ns_s <= ns_in;
         ew_s <= ew_in;
         if (force_red_p) begin
            ns_p <= C_RED;
            ew_p <= C_RED;
         end else begin
            ns_p <= ns_s;
            ew_p <= ew_s;
         end
      end
   end

   // Per-approach yellow run length, saturating at the minimum so a Y->R step can be judged
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ns_yc <= '0;
         ew_yc <= '0;
      end else begin
         ns_yc <= (ns_s != C_YEL) ? '0 : (ns_yc == YEL_MAX) ? YEL_MAX : ns_yc + YW'(1);
         ew_yc <= (ew_s != C_YEL) ? '0 : (ew_yc == YEL_MAX) ? YEL_MAX : ew_yc + YW'(1);
      end
   end

   // Fault classification of the stage-1 values, lowest code wins
   always_comb begin
      det_code = 3'b000;
      if (ns_s == C_BAD || ew_s == C_BAD)
         det_code = 3'b001;
      else if (ns_s != C_RED && ew_s != C_RED)
         det_code = 3'b010;
      else if (illegal_step(ns_p, ns_s) || illegal_step(ew_p, ew_s))
         det_code = 3'b011;
      else if ((ns_p == C_YEL && ns_s == C_RED && ns_yc < YEL_MAX) ||
               (ew_p == C_YEL && ew_s == C_RED && ew_yc < YEL_MAX))
         det_code = 3'b100;
   end

   // Next-state and next-output logic for the NORMAL / FAULT / RECOVER controller
   always_comb begin
      state_n      = state;
      ns_lamp_n    = ns_lamp;
      ew_lamp_n    = ew_lamp;
      fault_n      = fault;
      fault_code_n = fault_code;
      flash_cnt_n  = flash_cnt;
      rec_cnt_n    = rec_cnt;
      force_red_p  = 1'b0;
      case (state)
         ST_NORMAL: begin
            if (det_code != 3'b000) begin
               state_n      = ST_FAULT;
               fault_n      = 1'b1;
               fault_code_n = det_code;
               ns_lamp_n    = LAMP_RED;
               ew_lamp_n    = LAMP_RED;
               flash_cnt_n  = '0;
            end else begin
               ns_lamp_n = decode(ns_s);
               ew_lamp_n = decode(ew_s);
            end
         end
         ST_FAULT: begin
            if (fault_clr) begin
               state_n   = ST_RECOVER;
               ns_lamp_n = LAMP_RED;
               ew_lamp_n = LAMP_RED;
               rec_cnt_n = '0;
            end else if (flash_cnt == FLASH_LAST) begin
               flash_cnt_n = '0;
               ns_lamp_n   = {~ns_lamp[2], 2'b00};
               ew_lamp_n   = {~ns_lamp[2], 2'b00};
            end else begin
               flash_cnt_n = flash_cnt + FW'(1);
            end
         end
         ST_RECOVER: begin
            ns_lamp_n = LAMP_RED;
            ew_lamp_n = LAMP_RED;
            if (ns_s == C_RED && ew_s == C_RED) begin
               if (rec_cnt == REC_LAST) begin
                  state_n      = ST_NORMAL;
                  fault_n      = 1'b0;
                  fault_code_n = 3'b000;
                  rec_cnt_n    = '0;
                  force_red_p  = 1'b1;
               end else begin
                  rec_cnt_n = rec_cnt + RW'(1);
               end
            end else begin
               rec_cnt_n = '0;
            end
         end
         default: state_n = ST_NORMAL;
      endcase
   end

   // Controller state, counters and registered lamp/fault outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= ST_NORMAL;
         ns_lamp    <= LAMP_RED;
         ew_lamp    <= LAMP_RED;
         fault      <= 1'b0;
         fault_code <= 3'b000;
         flash_cnt  <= '0;
         rec_cnt    <= '0;
      end else begin
         state      <= state_n;
         ns_lamp    <= ns_lamp_n;
         ew_lamp    <= ew_lamp_n;
         fault      <= fault_n;
         fault_code <= fault_code_n;
         flash_cnt  <= flash_cnt_n;
         rec_cnt    <= rec_cnt_n;
      end
   end

endmodule
